clk_divider_multi: RTL
======================

# clk_divider_multi

Parametrised, multi-channel successor to the single-ratio clock divider in the conv_tree clock tree. It generates NUM_CH independent divided clocks from one source clock. Each channel has a run-time programmable ratio, changes ratio only at a period boundary, and starts and stops without glitches. A global sync input phase-aligns all channels. Each channel also provides a one-cycle tick strobe, so downstream conv stages can use it either as a derived clock or as a clock enable in the `clk_i` domain.

## Interface
Parameters:
- NUM_CH, 4: number of independent divider channels (≥1)
- DIV_W, 8: width of each divide-ratio field
- DEFAULT_DIV, 2: ratio loaded into every channel at reset (2 ≤ DEFAULT_DIV ≤ 2^DIV_W−1)

Ports:
- clk_i  in  1  source clock; single clock domain, all logic on posedge
- rst_i  in  1  reset; synchronous, active-high
- en_i  in  NUM_CH  per-channel run enable (level)
- load_i  in  NUM_CH  per-channel one-cycle strobe: capture the new ratio
- div_i  in  NUM_CH*DIV_W  ratio values; channel c is div_i[c*DIV_W +: DIV_W]
- sync_i  in  1  one-cycle strobe: restart all running channels at phase 0
- clk_o  out  NUM_CH  divided clocks, each driven directly by a flop
- tick_o  out  NUM_CH  one-cycle pulse in the cycle a channel's period starts
- active_o  out  NUM_CH  channel is running
- pend_o  out  NUM_CH  a loaded ratio is waiting for the period boundary

## Operation
Per-channel state:
- cnt (DIV_W): phase counter
- ratio N (DIV_W): active ratio
- pend_ratio and pend flag: staged ratio
- run flag

Loading and ratio rules:
- Ratios of 0 or 1 are clamped to 2 when captured; the minimum output is clk_i/2.
- High time H = N>>1 cycles; low time = N−H, so odd N is low-heavy. Example: N=5 gives 2 high, 3 low.

Running channel:
- cnt counts 0..N−1 and then wraps to 0.
- clk_o=1 while cnt<H; tick_o=1 while cnt==0.

Ratio change:
- load_i captures div_i into pend_ratio and sets pend.
- A second load before the boundary overwrites pend_ratio.
- On wrap (cnt==N−1), N←pend_ratio and pend clears; the new period starts with the new ratio.
- If the channel is idle, a load takes effect on the next cycle. pend_o pulses for at most 1 cycle in this case.

Enable and disable:
- en_i rising while the channel is idle: next cycle run=1, cnt=0, clk_o=1, tick_o=1.
- en_i low while running: the current period completes. At the wrap the channel goes idle (run=0, cnt=0, clk_o=0, tick_o=0). No truncated high or low phase is produced.
- en_i re-asserted before that wrap: the channel keeps running with no gap.

Sync:
- sync_i forces every channel with run=1 or a rising en_i to cnt=0 next cycle, with clk_o=1 and tick_o=1.
- Any pending ratio is applied at that point.
- sync_i truncates the current period. This is the only operation allowed to do so.

Simultaneous events:
- load_i and a wrap in the same cycle: the wrap applies the old pend_ratio, or keeps N if there was none. The new value is staged for the next boundary.
- sync_i and load_i in the same cycle: the restart uses the new ratio.
- sync_i on an idle channel with en_i low: no effect.

## Timing
Reset values:
- clk_o=0, tick_o=0, active_o=0, pend_o=0
- cnt=0, every N=DEFAULT_DIV, no pending ratios

Latencies:
- Enable to first clk_o high: 1 cycle. en_i is sampled at edge t, and clk_o=1 in cycle t+1.
- Output period: exactly N clk_i cycles, with one tick_o per period.
- Ratio change at boundary: the first period with the new N starts the cycle after the cnt==N−1 cycle.

Reset mid-operation:
- rst_i overrides every input in the same edge.
- All outputs are at their reset values the next cycle; the next cycle can truncate a clk_o high phase.

## Test plan
1. **Reset, then enable:** reset, then en_i[0]=1 with DEFAULT_DIV=2 → clk_o[0] toggles 1,0,1,0 starting 1 cycle after enable; tick_o every 2 cycles; active_o[0]=1.
2. **Odd ratio:** load div=5 on idle ch1, enable → clk_o[1] high 2 cycles, low 3, period 5; tick_o[1] once per 5 cycles. Load div=0 → behaves as 2.
3. **Mid-period load:** ch0 running at N=4; load 6 at cnt=1 → pend_o=1 until the wrap; the current period stays 4 cycles; the next periods are 6 cycles with 3 high.
4. **Disable mid-period:** ch0 at N=8; en_i low at cnt=2 → 8-cycle period completes; then clk_o=0, active_o=0, with no short pulse.
5. **Sync:** ch0 N=4 and ch1 N=6 running, out of phase; pulse sync_i → both show tick_o=1 and clk_o=1 the same cycle; their ticks coincide every 12 cycles.
6. **Reset mid-operation:** rst_i while clk_o=1 with a ratio pending → all outputs 0 next cycle; after release, an enabled channel restarts at DEFAULT_DIV.

Source files
------------

// File: rtl/clk_divider_multi.sv
// NUM_CH independent programmable clock dividers sharing one source clock.
// Each channel changes ratio and stops only at a period boundary; sync_i restarts every running channel at phase 0.
module clk_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       active_o,
    output logic [NUM_CH-1:0]       pend_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_t;

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_N = DIV_W'(2);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t        r_state, w_state_nx;
        logic [DIV_W-1:0] r_cnt, w_cnt_nx;
        logic [DIV_W-1:0] r_n, w_n_nx;
        logic [DIV_W-1:0] r_pend_ratio, w_pend_ratio_nx;
        logic             r_pend, w_pend_nx;
        logic             r_clk, w_clk_nx;
        logic             r_tick, w_tick_nx;
        logic [DIV_W-1:0] w_div, w_ld_ratio, w_staged;
        logic             w_wrap;

        assign w_div      = div_i[c*DIV_W +: DIV_W];
        assign w_ld_ratio = (w_div < MIN_N) ? MIN_N : w_div;
        assign w_staged   = r_pend ? r_pend_ratio : r_n;
        assign w_wrap     = (r_cnt == r_n - DIV_W'(1));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_n          <= DEF_N;
                r_pend_ratio <= DEF_N;
                r_pend       <= 1'b0;
                r_clk        <= 1'b0;
                r_tick       <= 1'b0;
            end else begin
                r_state      <= w_state_nx;
                r_cnt        <= w_cnt_nx;
                r_n          <= w_n_nx;
                r_pend_ratio <= w_pend_ratio_nx;
                r_pend       <= w_pend_nx;
                r_clk        <= w_clk_nx;
                r_tick       <= w_tick_nx;
            end
        end

        always_comb begin
            w_state_nx      = r_state;
            w_cnt_nx        = r_cnt;
            w_n_nx          = r_n;
            w_pend_ratio_nx = r_pend_ratio;
            w_pend_nx       = r_pend;
            case (r_state)
                ST_IDLE: begin
                    // Idle channels apply any ratio immediately; sync with en_i high is just a start.
                    w_n_nx    = load_i[c] ? w_ld_ratio : w_staged;
                    w_pend_nx = 1'b0;
                    w_cnt_nx  = '0;
                    if (en_i[c]) begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sync_i) begin
                        w_n_nx    = load_i[c] ? w_ld_ratio : w_staged;
                        w_pend_nx = 1'b0;
                        w_cnt_nx  = '0;
                    end else if (w_wrap) begin
                        w_n_nx    = w_staged;
                        w_pend_nx = load_i[c];
                        if (load_i[c]) begin
                            w_pend_ratio_nx = w_ld_ratio;
                        end
                        w_cnt_nx = '0;
                        if (!en_i[c]) begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + DIV_W'(1);
                        if (load_i[c]) begin
                            w_pend_nx       = 1'b1;
                            w_pend_ratio_nx = w_ld_ratio;
                        end
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
            // Outputs are derived from the next state so clk_o/tick_o come straight off flops.
            w_clk_nx  = (w_state_nx == ST_RUN) && (w_cnt_nx < (w_n_nx >> 1));
            w_tick_nx = (w_state_nx == ST_RUN) && (w_cnt_nx == '0);
        end

        assign clk_o[c]    = r_clk;
        assign tick_o[c]   = r_tick;
        assign active_o[c] = (r_state == ST_RUN);
        assign pend_o[c]   = r_pend;
    end

endmodule
